// File: rtl/id_exe_pkg.sv
// id_exe_pkg: shared widths, control bundle, bubble encoding and load-select helper
// for the ID/EXE pipeline register.
package id_exe_pkg;

    localparam int unsigned DATA_W_DEF  = 32;
    localparam int unsigned RADDR_W_DEF = 5;
    localparam int unsigned ALUOP_W     = 4;

    // Control bits carried from ID into EXE.
    typedef struct packed {
        logic               valid;
        logic               regDst;
        logic               memRead;
        logic               memWrite;
        logic               regWrite;
        logic               memToReg;
        logic               aluSrc;
        logic               usesRt;
        logic [ALUOP_W-1:0] aluOp;
    } ctrl_t;

    // A bubble carries no side effects: no valid, no register or memory write, no load.
    localparam ctrl_t BUBBLE_CTRL = '0;

    // What the EXE register bank does on the next rising edge.
    typedef enum logic [2:0] {
        LdHold,
        LdFlush,
        LdStall,
        LdEmpty,
        LdInstr
    } load_e;

    // Edge priority: hold, then flush, then load-use hazard, then the normal load.
    function automatic load_e sel_load(input logic hold, input logic flush,
                                       input logic hazard, input logic valid);
        load_e sel;
        if (hold) begin
            sel = LdHold;
        end else if (flush) begin
            sel = LdFlush;
        end else if (hazard) begin
            sel = LdStall;
        end else if (!valid) begin
            sel = LdEmpty;
        end else begin
            sel = LdInstr;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use hazard check between the load in EXE and the
// instruction waiting in ID.
module hazard_detect
    import id_exe_pkg::*;
#(
    parameter int unsigned RADDR_W = RADDR_W_DEF
) (
    input  logic               i_exe_memRead,
    input  logic               i_nop_exe,
    input  logic               i_id_valid,
    input  logic               i_id_usesRt,
    input  logic [RADDR_W-1:0] i_exe_outReg,
    input  logic [RADDR_W-1:0] i_id_rs,
    input  logic [RADDR_W-1:0] i_id_rt,
    output logic               o_hazard
);

    logic w_dst_live;
    logic w_rs_hit;
    logic w_rt_hit;

    // A live load into a non-zero register that ID reads as rs, or as rt when rt is used.
    always_comb begin
        w_dst_live = i_exe_memRead & ~i_nop_exe & (i_exe_outReg != '0);
        w_rs_hit   = (i_exe_outReg == i_id_rs);
        w_rt_hit   = i_id_usesRt & (i_exe_outReg == i_id_rt);
        o_hazard   = w_dst_live & i_id_valid & (w_rs_hit | w_rt_hit);
    end

endmodule

// File: rtl/id_exe_stage.sv
// id_exe_stage: ID/EXE pipeline register with hold, flush and one-cycle load-use interlock.
// Optional feature macro ID_EXE_PERF_CNT_EN adds saturating stall_cnt / flush_cnt outputs.
module id_exe_stage
    import id_exe_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned RADDR_W = RADDR_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               id_valid,
    input  logic               id_regDst,
    input  logic               id_memRead,
    input  logic               id_memWrite,
    input  logic               id_regWrite,
    input  logic               id_memToReg,
    input  logic               id_aluSrc,
    input  logic               id_usesRt,
    input  logic [ALUOP_W-1:0] id_aluOp,
    input  logic [DATA_W-1:0]  id_pc,
    input  logic [DATA_W-1:0]  id_rs_data,
    input  logic [DATA_W-1:0]  id_rt_data,
    input  logic [DATA_W-1:0]  id_imm,
    input  logic [RADDR_W-1:0] id_rs,
    input  logic [RADDR_W-1:0] id_rt,
    input  logic [RADDR_W-1:0] id_rd,
    input  logic               hold,
    input  logic               flush,
    output logic               exe_valid,
    output logic               exe_regDst,
    output logic               exe_memRead,
    output logic               exe_memWrite,
    output logic               exe_regWrite,
    output logic               exe_memToReg,
    output logic               exe_aluSrc,
    output logic               exe_usesRt,
    output logic [ALUOP_W-1:0] exe_aluOp,
    output logic [DATA_W-1:0]  exe_pc,
    output logic [DATA_W-1:0]  exe_rs_data,
    output logic [DATA_W-1:0]  exe_rt_data,
    output logic [DATA_W-1:0]  exe_imm,
    output logic [RADDR_W-1:0] exe_rs,
    output logic [RADDR_W-1:0] exe_rt,
    output logic [RADDR_W-1:0] exe_rd,
    output logic [RADDR_W-1:0] exe_outReg,
    output logic               nop_exe,
`ifdef ID_EXE_PERF_CNT_EN
    output logic [31:0]        stall_cnt,
    output logic [31:0]        flush_cnt,
`endif
    output logic               stall_id
);

    ctrl_t              w_id_ctrl;
    ctrl_t              r_ctrl;
    logic               r_nop;
    logic [RADDR_W-1:0] r_out_reg;
    logic [RADDR_W-1:0] r_rs;
    logic [RADDR_W-1:0] r_rt;
    logic [RADDR_W-1:0] r_rd;
    logic [DATA_W-1:0]  r_pc;
    logic [DATA_W-1:0]  r_rs_data;
    logic [DATA_W-1:0]  r_rt_data;
    logic [DATA_W-1:0]  r_imm;
    logic               w_hazard;
    load_e              w_load;

    assign w_id_ctrl = '{
        valid:    id_valid,
        regDst:   id_regDst,
        memRead:  id_memRead,
        memWrite: id_memWrite,
        regWrite: id_regWrite,
        memToReg: id_memToReg,
        aluSrc:   id_aluSrc,
        usesRt:   id_usesRt,
        aluOp:    id_aluOp
    };

    hazard_detect #(
        .RADDR_W (RADDR_W)
    ) u_hazard_detect (
        .i_exe_memRead (r_ctrl.memRead),
        .i_nop_exe     (r_nop),
        .i_id_valid    (id_valid),
        .i_id_usesRt   (id_usesRt),
        .i_exe_outReg  (r_out_reg),
        .i_id_rs       (id_rs),
        .i_id_rt       (id_rt),
        .o_hazard      (w_hazard)
    );

    // A flush squashes ID anyway, so it must not also freeze the front end.
    assign stall_id = w_hazard & ~flush;
    assign w_load   = sel_load(hold, flush, w_hazard, id_valid);

    // EXE register bank: hold keeps state, bubbles clear control, otherwise load from ID.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl    <= BUBBLE_CTRL;
            r_nop     <= 1'b1;
            r_out_reg <= '0;
            r_rs      <= '0;
            r_rt      <= '0;
            r_rd      <= '0;
            r_pc      <= '0;
            r_rs_data <= '0;
            r_rt_data <= '0;
            r_imm     <= '0;
        end else begin
            unique case (w_load)
                LdHold: begin
                end
                LdInstr: begin
                    r_ctrl    <= w_id_ctrl;
                    r_nop     <= 1'b0;
                    r_out_reg <= id_regDst ? id_rd : id_rt;
                    r_rs      <= id_rs;
                    r_rt      <= id_rt;
                    r_rd      <= id_rd;
                    r_pc      <= id_pc;
                    r_rs_data <= id_rs_data;
                    r_rt_data <= id_rt_data;
                    r_imm     <= id_imm;
                end
                default: begin
                    // Bubble: data fields are left as they are, nobody consumes them.
                    r_ctrl    <= BUBBLE_CTRL;
                    r_nop     <= 1'b1;
                    r_out_reg <= '0;
                    r_rs      <= '0;
                    r_rt      <= '0;
                    r_rd      <= '0;
                end
            endcase
        end
    end

    assign exe_valid    = r_ctrl.valid;
    assign exe_regDst   = r_ctrl.regDst;
    assign exe_memRead  = r_ctrl.memRead;
    assign exe_memWrite = r_ctrl.memWrite;
    assign exe_regWrite = r_ctrl.regWrite;
    assign exe_memToReg = r_ctrl.memToReg;
    assign exe_aluSrc   = r_ctrl.aluSrc;
    assign exe_usesRt   = r_ctrl.usesRt;
    assign exe_aluOp    = r_ctrl.aluOp;
    assign exe_pc       = r_pc;
    assign exe_rs_data  = r_rs_data;
    assign exe_rt_data  = r_rt_data;
    assign exe_imm      = r_imm;
    assign exe_rs       = r_rs;
    assign exe_rt       = r_rt;
    assign exe_rd       = r_rd;
    assign exe_outReg   = r_out_reg;
    assign nop_exe      = r_nop;

`ifdef ID_EXE_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    // Saturating event counters; hold maps to LdHold so both freeze with the stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if ((w_load == LdStall) && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if ((w_load == LdFlush) && (r_flush_cnt != 32'hFFFF_FFFF)) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_id_exe_stage.sv
// tb_id_exe_stage: directed scenarios plus randomized traffic against a rule-level model.
// Counter checks are compiled in only when ID_EXE_PERF_CNT_EN is defined.
module tb_id_exe_stage;

    typedef struct {
        logic        valid, regDst, memRead, memWrite, regWrite, memToReg, aluSrc, usesRt;
        logic [3:0]  aluOp;
        logic [31:0] pc, rsd, rtd, imm;
        logic [4:0]  rs, rt, rd;
    } ins_t;

    logic        clk;
    logic        rst_n;
    logic        id_valid, id_regDst, id_memRead, id_memWrite, id_regWrite;
    logic        id_memToReg, id_aluSrc, id_usesRt;
    logic [3:0]  id_aluOp;
    logic [31:0] id_pc, id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        hold, flush;
    logic        exe_valid, exe_regDst, exe_memRead, exe_memWrite, exe_regWrite;
    logic        exe_memToReg, exe_aluSrc, exe_usesRt;
    logic [3:0]  exe_aluOp;
    logic [31:0] exe_pc, exe_rs_data, exe_rt_data, exe_imm;
    logic [4:0]  exe_rs, exe_rt, exe_rd, exe_outReg;
    logic        nop_exe, stall_id;
`ifdef ID_EXE_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    int total = 0;
    int bad   = 0;

    id_exe_stage #(
        .DATA_W  (32),
        .RADDR_W (5)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_regDst    (id_regDst),
        .id_memRead   (id_memRead),
        .id_memWrite  (id_memWrite),
        .id_regWrite  (id_regWrite),
        .id_memToReg  (id_memToReg),
        .id_aluSrc    (id_aluSrc),
        .id_usesRt    (id_usesRt),
        .id_aluOp     (id_aluOp),
        .id_pc        (id_pc),
        .id_rs_data   (id_rs_data),
        .id_rt_data   (id_rt_data),
        .id_imm       (id_imm),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_rd        (id_rd),
        .hold         (hold),
        .flush        (flush),
        .exe_valid    (exe_valid),
        .exe_regDst   (exe_regDst),
        .exe_memRead  (exe_memRead),
        .exe_memWrite (exe_memWrite),
        .exe_regWrite (exe_regWrite),
        .exe_memToReg (exe_memToReg),
        .exe_aluSrc   (exe_aluSrc),
        .exe_usesRt   (exe_usesRt),
        .exe_aluOp    (exe_aluOp),
        .exe_pc       (exe_pc),
        .exe_rs_data  (exe_rs_data),
        .exe_rt_data  (exe_rt_data),
        .exe_imm      (exe_imm),
        .exe_rs       (exe_rs),
        .exe_rt       (exe_rt),
        .exe_rd       (exe_rd),
        .exe_outReg   (exe_outReg),
        .nop_exe      (nop_exe),
`ifdef ID_EXE_PERF_CNT_EN
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt),
`endif
        .stall_id     (stall_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input ins_t i);
        id_valid    = i.valid;
        id_regDst   = i.regDst;
        id_memRead  = i.memRead;
        id_memWrite = i.memWrite;
        id_regWrite = i.regWrite;
        id_memToReg = i.memToReg;
        id_aluSrc   = i.aluSrc;
        id_usesRt   = i.usesRt;
        id_aluOp    = i.aluOp;
        id_pc       = i.pc;
        id_rs_data  = i.rsd;
        id_rt_data  = i.rtd;
        id_imm      = i.imm;
        id_rs       = i.rs;
        id_rt       = i.rt;
        id_rd       = i.rd;
    endtask

    function automatic ins_t mk(input logic mr, input logic rdst, input logic ur,
                                input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] rd);
        ins_t i;
        i.valid    = 1'b1;
        i.regDst   = rdst;
        i.memRead  = mr;
        i.memWrite = 1'b0;
        i.regWrite = 1'b1;
        i.memToReg = mr;
        i.aluSrc   = mr;
        i.usesRt   = ur;
        i.aluOp    = 4'h2;
        i.pc       = $urandom;
        i.rsd      = $urandom;
        i.rtd      = $urandom;
        i.imm      = $urandom;
        i.rs       = rs;
        i.rt       = rt;
        i.rd       = rd;
        return i;
    endfunction

    task automatic do_reset();
        ins_t i;
        i = mk(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        i.valid = 1'b0;
        drive(i);
        hold  = 1'b0;
        flush = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        ins_t a, b;
        hold  = 1'b0;
        flush = 1'b0;
        rst_n = 1'b1;
        a = mk(1'b0, 1'b1, 1'b1, 5'd3, 5'd4, 5'd5);
        drive(a);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (nop_exe !== 1'b1) begin
            bad++; $display("FAIL reset_async_nop: got %b want 1", nop_exe);
        end
        total++;
        if ({exe_valid, exe_regWrite, exe_memRead, exe_memWrite, exe_outReg, exe_pc} !== '0) begin
            bad++;
            $display("FAIL reset_async_fields: got v=%b rw=%b mr=%b mw=%b out=%0d pc=%0h want 0",
                     exe_valid, exe_regWrite, exe_memRead, exe_memWrite, exe_outReg, exe_pc);
        end
        tick();
        total++;
        if ({nop_exe, exe_valid} !== 2'b10) begin
            bad++; $display("FAIL reset_held: got nop=%b v=%b want nop=1 v=0", nop_exe, exe_valid);
        end
        rst_n = 1'b1;
        b = mk(1'b0, 1'b1, 1'b0, 5'd1, 5'd2, 5'd6);
        drive(b);
        tick();
        total++;
        if ({nop_exe, exe_valid, exe_outReg} !== {1'b0, 1'b1, 5'd6} || exe_pc !== b.pc) begin
            bad++;
            $display("FAIL reset_first_load: got nop=%b v=%b out=%0d pc=%0h want 0 1 6 %0h",
                     nop_exe, exe_valid, exe_outReg, exe_pc, b.pc);
        end
    endtask

    task automatic test_load_use();
        ins_t lw, add;
        do_reset();
        lw = mk(1'b1, 1'b0, 1'b1, 5'd1, 5'd2, 5'd0);
        drive(lw);
        tick();
        total++;
        if ({exe_memRead, exe_outReg} !== {1'b1, 5'd2}) begin
            bad++; $display("FAIL lu_lw_exe: got mr=%b out=%0d want 1 2", exe_memRead, exe_outReg);
        end
        add = mk(1'b0, 1'b1, 1'b1, 5'd2, 5'd4, 5'd3);
        drive(add);
        #1;
        total++;
        if (stall_id !== 1'b1) begin
            bad++; $display("FAIL lu_stall: got %b want 1", stall_id);
        end
        tick();
        total++;
        if ({nop_exe, exe_valid, exe_regWrite, exe_memRead, exe_memWrite, exe_outReg}
            !== {1'b1, 4'b0, 5'd0}) begin
            bad++;
            $display("FAIL lu_bubble: got nop=%b v=%b rw=%b mr=%b mw=%b out=%0d want 1 0 0 0 0 0",
                     nop_exe, exe_valid, exe_regWrite, exe_memRead, exe_memWrite, exe_outReg);
        end
        total++;
        if (stall_id !== 1'b0) begin
            bad++; $display("FAIL lu_one_cycle: got stall=%b want 0", stall_id);
        end
        tick();
        total++;
        if ({nop_exe, exe_rs, exe_outReg} !== {1'b0, 5'd2, 5'd3} || exe_rs_data !== add.rsd) begin
            bad++;
            $display("FAIL lu_enter: got nop=%b rs=%0d out=%0d rsd=%0h want 0 2 3 %0h",
                     nop_exe, exe_rs, exe_outReg, exe_rs_data, add.rsd);
        end
`ifdef ID_EXE_PERF_CNT_EN
        total++;
        if ({stall_cnt, flush_cnt} !== {32'd1, 32'd0}) begin
            bad++; $display("FAIL lu_cnt: got s=%0d f=%0d want 1 0", stall_cnt, flush_cnt);
        end
`endif
    endtask

    task automatic test_zero_reg();
        ins_t lw0, u;
        do_reset();
        lw0 = mk(1'b1, 1'b0, 1'b1, 5'd1, 5'd0, 5'd0);
        drive(lw0);
        tick();
        u = mk(1'b0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd8);
        drive(u);
        #1;
        total++;
        if (stall_id !== 1'b0) begin
            bad++; $display("FAIL zero_reg_stall: got %b want 0", stall_id);
        end
        tick();
        total++;
        if ({nop_exe, exe_valid, exe_outReg} !== {1'b0, 1'b1, 5'd8}) begin
            bad++;
            $display("FAIL zero_reg_load: got nop=%b v=%b out=%0d want 0 1 8",
                     nop_exe, exe_valid, exe_outReg);
        end
    endtask

    task automatic test_flush_hazard();
        ins_t lw5, u;
        do_reset();
        lw5 = mk(1'b1, 1'b0, 1'b1, 5'd1, 5'd5, 5'd0);
        drive(lw5);
        tick();
        u = mk(1'b0, 1'b1, 1'b0, 5'd5, 5'd1, 5'd9);
        drive(u);
        #1;
        total++;
        if (stall_id !== 1'b1) begin
            bad++; $display("FAIL fh_pre_stall: got %b want 1", stall_id);
        end
        flush = 1'b1;
        #1;
        total++;
        if (stall_id !== 1'b0) begin
            bad++; $display("FAIL fh_stall_masked: got %b want 0", stall_id);
        end
        tick();
        total++;
        if ({nop_exe, exe_valid, exe_memRead, exe_outReg} !== {1'b1, 2'b0, 5'd0}) begin
            bad++;
            $display("FAIL fh_bubble: got nop=%b v=%b mr=%b out=%0d want 1 0 0 0",
                     nop_exe, exe_valid, exe_memRead, exe_outReg);
        end
`ifdef ID_EXE_PERF_CNT_EN
        total++;
        if ({stall_cnt, flush_cnt} !== {32'd0, 32'd1}) begin
            bad++; $display("FAIL fh_cnt: got s=%0d f=%0d want 0 1", stall_cnt, flush_cnt);
        end
`endif
        flush = 1'b0;
        tick();
        total++;
        if ({nop_exe, exe_rs, exe_outReg} !== {1'b0, 5'd5, 5'd9}) begin
            bad++;
            $display("FAIL fh_after: got nop=%b rs=%0d out=%0d want 0 5 9",
                     nop_exe, exe_rs, exe_outReg);
        end
    endtask

    task automatic test_hold();
        ins_t a, n, c;
        do_reset();
        a = mk(1'b1, 1'b1, 1'b1, 5'd1, 5'd2, 5'd4);
        drive(a);
        tick();
        hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n = mk(1'b0, 1'b1, 1'b1, (k == 1) ? 5'd4 : 5'd1, 5'd2, 5'(10 + k));
            drive(n);
            flush = (k == 2);
            #1;
            total++;
            if (stall_id !== (k == 1)) begin
                bad++; $display("FAIL hold_stall_%0d: got %b want %b", k, stall_id, (k == 1));
            end
            tick();
            total++;
            if ({nop_exe, exe_valid, exe_memRead, exe_outReg} !== {1'b0, 1'b1, 1'b1, 5'd4}
                || exe_pc !== a.pc) begin
                bad++;
                $display("FAIL hold_keep_%0d: got nop=%b v=%b mr=%b out=%0d pc=%0h want 0 1 1 4 %0h",
                         k, nop_exe, exe_valid, exe_memRead, exe_outReg, exe_pc, a.pc);
            end
        end
`ifdef ID_EXE_PERF_CNT_EN
        total++;
        if ({stall_cnt, flush_cnt} !== 64'd0) begin
            bad++; $display("FAIL hold_cnt: got s=%0d f=%0d want 0 0", stall_cnt, flush_cnt);
        end
`endif
        hold  = 1'b0;
        flush = 1'b0;
        c = mk(1'b0, 1'b1, 1'b0, 5'd1, 5'd2, 5'd7);
        drive(c);
        tick();
        total++;
        if ({nop_exe, exe_outReg} !== {1'b0, 5'd7} || exe_pc !== c.pc) begin
            bad++;
            $display("FAIL hold_release: got nop=%b out=%0d pc=%0h want 0 7 %0h",
                     nop_exe, exe_outReg, exe_pc, c.pc);
        end
    endtask

    task automatic test_reset_mid_stall();
        ins_t lw6, s;
        do_reset();
        lw6 = mk(1'b1, 1'b0, 1'b1, 5'd1, 5'd6, 5'd0);
        drive(lw6);
        tick();
        s = mk(1'b0, 1'b1, 1'b1, 5'd6, 5'd2, 5'd3);
        drive(s);
        #1;
        total++;
        if (stall_id !== 1'b1) begin
            bad++; $display("FAIL rms_stall: got %b want 1", stall_id);
        end
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if ({nop_exe, exe_regWrite, exe_memRead, stall_id} !== 4'b1000) begin
            bad++;
            $display("FAIL rms_async: got nop=%b rw=%b mr=%b stall=%b want 1 0 0 0",
                     nop_exe, exe_regWrite, exe_memRead, stall_id);
        end
        tick();
        rst_n = 1'b1;
        tick();
        total++;
        if ({nop_exe, exe_rs, exe_outReg} !== {1'b0, 5'd6, 5'd3}) begin
            bad++;
            $display("FAIL rms_after: got nop=%b rs=%0d out=%0d want 0 6 3",
                     nop_exe, exe_rs, exe_outReg);
        end
    endtask

    task automatic test_outreg_sel();
        ins_t a, b;
        do_reset();
        a = mk(1'b1, 1'b0, 1'b1, 5'd1, 5'd9, 5'd5);
        drive(a);
        tick();
        total++;
        if (exe_outReg !== 5'd9) begin
            bad++; $display("FAIL sel_rt: got %0d want 9", exe_outReg);
        end
        b = mk(1'b0, 1'b1, 1'b0, 5'd1, 5'd9, 5'd3);
        drive(b);
        #1;
        total++;
        if (stall_id !== 1'b0) begin
            bad++; $display("FAIL sel_no_rt_use: got %b want 0", stall_id);
        end
        b.usesRt = 1'b1;
        drive(b);
        #1;
        total++;
        if (stall_id !== 1'b1) begin
            bad++; $display("FAIL sel_rt_use: got %b want 1", stall_id);
        end
        b.usesRt = 1'b0;
        drive(b);
        tick();
        total++;
        if ({nop_exe, exe_rs, exe_outReg} !== {1'b0, 5'd1, 5'd3}) begin
            bad++;
            $display("FAIL sel_load: got nop=%b rs=%0d out=%0d want 0 1 3",
                     nop_exe, exe_rs, exe_outReg);
        end
    endtask

    task automatic test_random();
        ins_t        m_exe, cur;
        logic        m_bub, h, f, e_haz;
        logic [4:0]  e_dst;
        int unsigned m_sc, m_fc;
        logic [9:0]  got_ctl, exp_ctl;
        logic [150:0] got_full, exp_full;
        do_reset();
        m_exe = mk(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        m_bub = 1'b1;
        m_sc  = 0;
        m_fc  = 0;
        for (int it = 0; it < 400; it++) begin
            cur          = mk(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                              1'($urandom_range(1, 0)), 5'($urandom_range(3, 0)),
                              5'($urandom_range(3, 0)), 5'($urandom_range(3, 0)));
            cur.valid    = ($urandom_range(7, 0) != 0);
            cur.memWrite = 1'($urandom_range(1, 0));
            cur.regWrite = 1'($urandom_range(1, 0));
            cur.aluSrc   = 1'($urandom_range(1, 0));
            cur.aluOp    = 4'($urandom_range(15, 0));
            h = ($urandom_range(7, 0) == 0);
            f = ($urandom_range(7, 0) == 0);
            hold  = h;
            flush = f;
            drive(cur);
            #1;
            // A live load whose destination the ID instruction reads; $0 is exempt.
            e_dst = m_exe.regDst ? m_exe.rd : m_exe.rt;
            e_haz = !m_bub && m_exe.memRead && cur.valid && (e_dst != 5'd0) &&
                    ((e_dst == cur.rs) || (cur.usesRt && (e_dst == cur.rt)));
            total++;
            if (stall_id !== (e_haz && !f)) begin
                bad++;
                $display("FAIL rnd_stall_%0d: got %b want %b", it, stall_id, e_haz && !f);
            end
            if (!h) begin
                if (f) begin
                    m_bub = 1'b1;
                    m_fc++;
                end else if (e_haz) begin
                    m_bub = 1'b1;
                    m_sc++;
                end else if (!cur.valid) begin
                    m_bub = 1'b1;
                end else begin
                    m_bub = 1'b0;
                    m_exe = cur;
                end
            end
            tick();
            got_ctl = {nop_exe, exe_valid, exe_regWrite, exe_memRead, exe_memWrite, exe_outReg};
            if (m_bub) begin
                exp_ctl = {1'b1, 4'b0, 5'd0};
            end else begin
                exp_ctl = {1'b0, m_exe.valid, m_exe.regWrite, m_exe.memRead, m_exe.memWrite,
                           m_exe.regDst ? m_exe.rd : m_exe.rt};
            end
            total++;
            if (got_ctl !== exp_ctl) begin
                bad++; $display("FAIL rnd_ctl_%0d: got %0h want %0h", it, got_ctl, exp_ctl);
            end
            if (!m_bub) begin
                got_full = {exe_regDst, exe_memToReg, exe_aluSrc, exe_usesRt, exe_aluOp,
                            exe_pc, exe_rs_data, exe_rt_data, exe_imm, exe_rs, exe_rt, exe_rd};
                exp_full = {m_exe.regDst, m_exe.memToReg, m_exe.aluSrc, m_exe.usesRt,
                            m_exe.aluOp, m_exe.pc, m_exe.rsd, m_exe.rtd, m_exe.imm,
                            m_exe.rs, m_exe.rt, m_exe.rd};
                total++;
                if (got_full !== exp_full) begin
                    bad++; $display("FAIL rnd_data_%0d: got %0h want %0h", it, got_full, exp_full);
                end
            end
`ifdef ID_EXE_PERF_CNT_EN
            total++;
            if (stall_cnt !== m_sc || flush_cnt !== m_fc) begin
                bad++;
                $display("FAIL rnd_cnt_%0d: got s=%0d f=%0d want %0d %0d",
                         it, stall_cnt, flush_cnt, m_sc, m_fc);
            end
`endif
        end
        hold  = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_zero_reg();
        test_flush_hazard();
        test_hold();
        test_reset_mid_stall();
        test_outreg_sel();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_exe_stage.md
ID_EXE_STAGE -- requirements
Module: id_exe_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath and PC width.
REQ-002 SHALL have parameter RADDR_W, default 5, register-address width.
REQ-003 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports id_valid, id_regDst, id_memRead, id_memWrite, id_regWrite, id_memToReg, id_aluSrc, id_usesRt  in  1  ID-stage valid flag and control bits.
REQ-006 SHALL have port id_aluOp  in  4  ALU operation code.
REQ-007 SHALL have ports id_pc, id_rs_data, id_rt_data, id_imm  in  DATA_W  ID-stage operands.
REQ-008 SHALL have ports id_rs, id_rt, id_rd  in  RADDR_W  ID-stage register addresses.
REQ-009 SHALL have ports hold (global freeze) and flush (branch taken in EXE)  in  1.
REQ-010 SHALL have registered outputs exe_* mirroring every id_* port of REQ-005..REQ-008, widths unchanged; exe_valid replaces id_valid.
REQ-011 SHALL have port exe_outReg  out  RADDR_W  registered destination: id_rd if id_regDst=1, else id_rt.
REQ-012 SHALL have port nop_exe  out  1  high when EXE holds a bubble; consumed by the forwarding unit.
REQ-013 SHALL have port stall_id  out  1  combinational; upstream (PC, IF/ID) holds when high.

Function
REQ-014 SHALL register ID contents into EXE with 1-cycle latency when no hold, flush or stall is active.
REQ-015 SHALL compute hazard = exe_memRead & ~nop_exe & id_valid & (exe_outReg != 0) & ((exe_outReg == id_rs) | (id_usesRt & exe_outReg == id_rt)).
REQ-016 SHALL drive stall_id = hazard & ~flush.
REQ-017 SHALL apply per-edge priority: hold > flush > hazard > load.
REQ-018 SHALL keep all EXE registers unchanged while hold=1; stall_id still reflects REQ-016.
REQ-019 SHALL on flush (no hold) load a bubble: nop_exe=1, exe_valid=0, exe_regWrite=exe_memRead=exe_memWrite=0, exe_outReg=0.
REQ-020 SHALL on hazard (no hold, no flush) load the bubble of REQ-019; the stalled instruction enters EXE on the following edge.
REQ-021 SHALL load a bubble when id_valid=0.
REQ-022 SHALL limit a load-use stall to exactly one cycle: after the bubble, nop_exe=1 makes hazard=0.
REQ-023 SHALL leave data fields (pc, operands, imm) don't-care in a bubble; only control fields and nop_exe are defined.

Reset
REQ-024 SHALL on rst_n=0 immediately force nop_exe=1, all exe_* outputs and exe_outReg to 0, independent of clk.
REQ-025 SHALL after rst_n release, accept an instruction on the first rising edge.
REQ-026 SHALL on reset mid-stall discard the stalled instruction; stall_id falls to 0 with reset.

Configuration
REQ-027 SHALL, with ID_EXE_PERF_CNT_EN defined, add outputs stall_cnt and flush_cnt (32 bits each), counting edges where a hazard bubble resp. flush bubble is loaded, saturating at 0xFFFFFFFF, cleared by reset, frozen during hold.
REQ-028 SHALL, without ID_EXE_PERF_CNT_EN, have neither the counter ports nor their logic.

Structure
REQ-029 SHALL place DATA_W/RADDR_W defaults, ALUOP_W=4 and the bubble control encoding in shared package id_exe_pkg.
REQ-030 SHALL implement REQ-015 in a combinational sub-module hazard_detect; all registers live in id_exe_stage.

Verification
REQ-031 SHALL cover: lw $2 in EXE (exe_memRead=1, exe_outReg=2), ID add $3,$2,$4 -> stall_id=1, next edge nop_exe=1, following edge exe_rs=2 and nop_exe=0.
REQ-032 SHALL cover: lw $0 in EXE, ID reads rs=0 -> stall_id=0, no bubble.
REQ-033 SHALL cover: hazard and flush in same cycle -> stall_id=0, bubble loaded, stall_cnt unchanged, flush_cnt +1.
REQ-034 SHALL cover: hold=1 for 3 cycles with new id_* values -> exe_* unchanged, then id_rd=7, id_regDst=1 loads exe_outReg=7.
REQ-035 SHALL cover: rst_n pulled low between edges during a stall -> nop_exe=1, exe_regWrite=0, stall_id=0 before the next clk edge.
REQ-036 SHALL cover: id_regDst=0, id_rt=9, id_rd=5 -> exe_outReg=9; id_usesRt=0 with exe load to $9 and id_rs=1 -> stall_id=0.
